// File: rtl/avalon_wait_ram_if.sv
// avalon_wait_ram_if: Avalon-MM bus bundle between a CPU master and the wait-state RAM.
//   address/write/read/writedata/byteenable : master -> slave request signals
//   waitrequest/readdata                    : slave -> master response signals
interface avalon_wait_ram_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );
  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram: Avalon-MM slave RAM with programmable/random stalls, byte lanes, preload port and sticky error.
//   clk          : rising-edge clock
//   reset        : synchronous active-low reset
//   bus          : Avalon-MM slave port (address, read, write, writedata, byteenable, waitrequest, readdata)
//   preload_en   : side-port full-word write strobe, works during reset
//   preload_addr : side-port byte address, translated like the bus address
//   preload_data : side-port word data
//   bus_error    : sticky flag for accepted invalid requests, cleared by reset
module avalon_wait_ram #(
  parameter int          ADDR_BITS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1,
  parameter bit          RANDOM_WAIT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  avalon_wait_ram_if.slave    bus,
  input  logic                preload_en,
  input  logic [31:0]         preload_addr,
  input  logic [31:0]         preload_data,
  output logic                bus_error
);
  logic [31:0]          mem [2**ADDR_BITS];
  logic [31:0]          off;
  logic [31:0]          pre_off;
  logic [ADDR_BITS-1:0] word;
  logic [ADDR_BITS-1:0] pre_word;
  logic                 req;
  logic                 valid;
  logic                 pre_ok;
  logic                 stall;
  logic                 accept;
  logic [4:0]           tgt;
  logic [4:0]           cnt_q, cnt_d;
  logic [4:0]           tgt_q, tgt_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic                 err_q, err_d;
  always_comb begin
    off      = bus.address - BASE_ADDR;
    pre_off  = preload_addr - BASE_ADDR;
    word     = off[ADDR_BITS+1:2];
    pre_word = pre_off[ADDR_BITS+1:2];
    req      = bus.read | bus.write;
    // base is word-aligned, so offset alignment equals address alignment
    valid    = (off[31:ADDR_BITS+2] == '0) && (off[1:0] == 2'b00) && !(bus.read && bus.write);
    pre_ok   = (pre_off[31:ADDR_BITS+2] == '0) && (pre_off[1:0] == 2'b00);
    // the first cycle of a request uses the live target; later cycles use the captured one
    tgt      = (cnt_q == 5'd0) ? 5'(WAIT_CYCLES) + (RANDOM_WAIT ? {3'b000, lfsr_q[1:0]} : 5'd0) : tgt_q;
    stall    = !reset | (req & (cnt_q < tgt));
    accept   = req & !stall;
    cnt_d    = (req & stall) ? cnt_q + 5'd1 : 5'd0;
    tgt_d    = tgt;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    err_d    = err_q | (accept & !valid);
    bus.waitrequest = stall;
    bus.readdata    = (accept && valid && bus.read) ? mem[word] : 32'h0;
    bus_error       = err_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= 5'd0;
      tgt_q  <= 5'd0;
      lfsr_q <= 8'h01;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tgt_q  <= tgt_d;
      lfsr_q <= lfsr_d;
      err_q  <= err_d;
    end
  end
  // preload is issued last so it overrides a same-cycle bus write to the same word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (accept && valid && bus.write && bus.byteenable[i])
        mem[word][8*i +: 8] <= bus.writedata[8*i +: 8];
    if (preload_en && pre_ok)
      mem[pre_word] <= preload_data;
  end
endmodule

// File: tb/tb_avalon_wait_ram.sv
// tb_avalon_wait_ram: randomized self-checking bench over four differently configured instances.
module tb_avalon_wait_ram;
  localparam logic [15:0]  WCS   = {4'd4, 4'd2, 4'd0, 4'd1};
  localparam logic [3:0]   RWS   = 4'b0100;
  localparam logic [127:0] BASES = {32'h0, 32'h8000_0000, 32'h0, 32'h0};
  logic        clk;
  logic        rst_n [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic        rd_s  [4];
  logic        wr_s  [4];
  logic [3:0]  be    [4];
  logic        pe    [4];
  logic [31:0] pa    [4];
  logic [31:0] pd    [4];
  logic        wq    [4];
  logic [31:0] rq    [4];
  logic        berr  [4];
  logic [31:0] mdl   [4][256];
  int n_chk = 0;
  int n_fail = 0;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    avalon_wait_ram_if bus ();
    assign bus.address    = addr[g];
    assign bus.writedata  = wdata[g];
    assign bus.read       = rd_s[g];
    assign bus.write      = wr_s[g];
    assign bus.byteenable = be[g];
    assign wq[g]          = bus.waitrequest;
    assign rq[g]          = bus.readdata;
    avalon_wait_ram #(
      .ADDR_BITS(8),
      .BASE_ADDR(BASES[g*32 +: 32]),
      .WAIT_CYCLES(int'(WCS[g*4 +: 4])),
      .RANDOM_WAIT(RWS[g])
    ) dut (
      .clk(clk),
      .reset(rst_n[g]),
      .bus(bus),
      .preload_en(pe[g]),
      .preload_addr(pa[g]),
      .preload_data(pd[g]),
      .bus_error(berr[g])
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  function automatic bit map_addr(input int d, input logic [31:0] a, output int wi);
    logic [31:0] off;
    off = a - BASES[d*32 +: 32];
    wi = int'(off[9:2]);
    return (a % 4 == 0) && (off < 32'd1024);
  endfunction
  function automatic logic [31:0] exp_read(input int d, input logic [31:0] a);
    int wi;
    return map_addr(d, a, wi) ? mdl[d][wi] : 32'h0;
  endfunction
  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] data, input logic [3:0] lanes);
    int wi;
    if (map_addr(d, a, wi))
      for (int i = 0; i < 4; i++)
        if (lanes[i]) mdl[d][wi][8*i +: 8] = data[8*i +: 8];
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int d);
    rd_s[d] = 1'b0;
    wr_s[d] = 1'b0;
    tick();
  endtask
  task automatic preload(input int d, input logic [31:0] a, input logic [31:0] data);
    int wi;
    pe[d] = 1'b1;
    pa[d] = a;
    pd[d] = data;
    tick();
    pe[d] = 1'b0;
    if (map_addr(d, a, wi)) mdl[d][wi] = data;
  endtask
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] data,
                      input logic [3:0] lanes, output int stall, output logic [31:0] rd);
    addr[d]  = a;
    wdata[d] = data;
    be[d]    = lanes;
    wr_s[d]  = w;
    rd_s[d]  = !w;
    stall    = 0;
    #1;
    while (wq[d] === 1'b1 && stall < 40) begin
      n_chk++;
      if (rq[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL stall_rdata dut%0d: got %h, expected 0", d, rq[d]);
      end
      stall++;
      tick();
    end
    if (stall >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d addr %h: no accept within 40 cycles", d, a);
    end
    rd = rq[d];
    if (w) model_write(d, a, data, lanes);
    tick();
  endtask
  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      rst_n[d] = 1'b0; rd_s[d] = 1'b0; wr_s[d] = 1'b0; pe[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; be[d] = '0; pa[d] = '0; pd[d] = '0;
    end
    tick();
    preload(0, 32'h04, 32'h2402_0002);
    preload(0, 32'h00, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) preload(2, 32'h8000_0000 + 32'(4*i), $urandom);
    rd_s[0] = 1'b1;
    addr[0] = 32'h04;
    tick();
    for (int d = 0; d < 4; d++) begin
      n_chk++;
      if (wq[d] !== 1'b1) begin n_fail++; $display("FAIL reset_wait dut%0d: got %b, expected 1", d, wq[d]); end
      n_chk++;
      if (rq[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h, expected 0", d, rq[d]); end
      n_chk++;
      if (berr[d] !== 1'b0) begin n_fail++; $display("FAIL reset_berr dut%0d: got %b, expected 0", d, berr[d]); end
    end
    rd_s[0] = 1'b0;
    for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;
    tick();
  endtask
  task automatic test_basic_read();
    int st;
    logic [31:0] rd;
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, st, rd);
    n_chk++;
    if (st !== 1) begin n_fail++; $display("FAIL basic_stall: got %0d, expected 1", st); end
    n_chk++;
    if (rd !== 32'h2402_0002) begin n_fail++; $display("FAIL basic_rdata: got %h, expected 24020002", rd); end
    idle(0);
    n_chk++;
    if (rq[0] !== 32'h0) begin n_fail++; $display("FAIL basic_rdata_after: got %h, expected 0", rq[0]); end
    n_chk++;
    if (wq[0] !== 1'b0) begin n_fail++; $display("FAIL idle_wait: got %b, expected 0", wq[0]); end
  endtask
  task automatic test_byte_lanes();
    int st;
    logic [31:0] rd, a, exp;
    xfer(0, 1'b1, 32'h08, 32'h1122_3344, 4'hF, st, rd);
    xfer(0, 1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, st, rd);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, st, rd);
    n_chk++;
    if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL lanes_fixed: got %h, expected 11bb33dd", rd); end
    for (int i = 0; i < 16; i++) xfer(0, 1'b1, 32'h40 + 32'(4*i), $urandom, 4'hF, st, rd);
    for (int i = 0; i < 24; i++) begin
      a = 32'h40 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) xfer(0, 1'b1, a, $urandom, 4'($urandom), st, rd);
      else begin
        exp = exp_read(0, a);
        xfer(0, 1'b0, a, 32'h0, 4'($urandom), st, rd);
        n_chk++;
        if (rd !== exp) begin n_fail++; $display("FAIL lanes_rand addr %h: got %h, expected %h", a, rd, exp); end
      end
      n_chk++;
      if (st !== 1) begin n_fail++; $display("FAIL lanes_stall addr %h: got %0d, expected 1", a, st); end
    end
    idle(0);
  endtask
  task automatic test_back_to_back();
    int st_w, st_r;
    logic [31:0] rd, v, a, exp;
    v = $urandom;
    xfer(1, 1'b1, 32'h10, v, 4'hF, st_w, rd);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, st_r, rd);
    n_chk++;
    if (st_w !== 0 || st_r !== 0) begin n_fail++; $display("FAIL b2b_stall: got %0d/%0d, expected 0/0", st_w, st_r); end
    n_chk++;
    if (rd !== v) begin n_fail++; $display("FAIL b2b_rdata: got %h, expected %h", rd, v); end
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      xfer(1, 1'b1, a, $urandom, 4'hF, st_w, rd);
      exp = exp_read(1, a);
      xfer(1, 1'b0, a, 32'h0, 4'h0, st_r, rd);
      n_chk++;
      if (rd !== exp || st_w !== 0 || st_r !== 0) begin
        n_fail++;
        $display("FAIL b2b_rand addr %h: got %h stalls %0d/%0d, expected %h stalls 0/0", a, rd, st_w, st_r, exp);
      end
    end
    idle(1);
  endtask
  task automatic test_collision();
    int st;
    logic [31:0] rd;
    pe[1] = 1'b1; pa[1] = 32'h30; pd[1] = 32'h5A5A_0F0F;
    addr[1] = 32'h30; wdata[1] = 32'h1234_5678; be[1] = 4'hF; wr_s[1] = 1'b1;
    #1;
    n_chk++;
    if (wq[1] !== 1'b0) begin n_fail++; $display("FAIL collide_wait: got %b, expected 0", wq[1]); end
    tick();
    pe[1] = 1'b0;
    wr_s[1] = 1'b0;
    mdl[1][12] = 32'h5A5A_0F0F;
    xfer(1, 1'b0, 32'h30, 32'h0, 4'h0, st, rd);
    n_chk++;
    if (rd !== 32'h5A5A_0F0F) begin n_fail++; $display("FAIL collide_rdata: got %h, expected 5a5a0f0f", rd); end
    idle(1);
  endtask
  task automatic test_errors();
    int st;
    logic [31:0] rd;
    n_chk++;
    if (berr[0] !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b, expected 0", berr[0]); end
    xfer(0, 1'b0, 32'h402, 32'h0, 4'h0, st, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL err_misaligned_rdata: got %h, expected 0", rd); end
    n_chk++;
    if (berr[0] !== 1'b1) begin n_fail++; $display("FAIL err_raised: got %b, expected 1", berr[0]); end
    xfer(0, 1'b1, 32'h400, 32'h1234_5678, 4'hF, st, rd);
    idle(0);
    preload(0, 32'h400, 32'hBAD0_BAD0);
    preload(0, 32'h005, 32'hBAD1_BAD1);
    n_chk++;
    if (berr[0] !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, expected 1", berr[0]); end
    for (int i = 0; i < 2; i++) begin
      xfer(0, 1'b0, 32'(4*i), 32'h0, 4'h0, st, rd);
      n_chk++;
      if (rd !== exp_read(0, 32'(4*i))) begin
        n_fail++;
        $display("FAIL err_mem_unchanged word %0d: got %h, expected %h", i, rd, exp_read(0, 32'(4*i)));
      end
    end
    idle(0);
    rst_n[0] = 1'b0;
    tick();
    n_chk++;
    if (berr[0] !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b, expected 0", berr[0]); end
    rst_n[0] = 1'b1;
    tick();
  endtask
  task automatic test_random_wait();
    int st;
    int sel [50];
    int stl [2][50];
    logic [31:0] rd, a, exp;
    logic [5:0] seen;
    for (int i = 0; i < 50; i++) sel[i] = $urandom_range(0, 3);
    seen = '0;
    for (int r = 0; r < 2; r++) begin
      rst_n[2] = 1'b0;
      idle(2);
      tick();
      rst_n[2] = 1'b1;
      tick();
      for (int i = 0; i < 50; i++) begin
        a = 32'h8000_0000 + 32'(4 * sel[i]);
        exp = exp_read(2, a);
        xfer(2, 1'b0, a, 32'h0, 4'h0, st, rd);
        stl[r][i] = st;
        n_chk++;
        if (st < 2 || st > 5) begin n_fail++; $display("FAIL rand_range run%0d #%0d: got %0d, expected 2..5", r, i, st); end
        n_chk++;
        if (rd !== exp) begin n_fail++; $display("FAIL rand_rdata run%0d #%0d: got %h, expected %h", r, i, rd, exp); end
        if (st >= 0 && st < 6) seen[st] = 1'b1;
      end
      idle(2);
    end
    for (int i = 0; i < 50; i++) begin
      n_chk++;
      if (stl[1][i] !== stl[0][i]) begin n_fail++; $display("FAIL rand_repeat #%0d: got %0d, expected %0d", i, stl[1][i], stl[0][i]); end
    end
    n_chk++;
    if ($countones(seen) < 2) begin n_fail++; $display("FAIL rand_variety: got %0d distinct stall lengths, expected at least 2", $countones(seen)); end
    xfer(2, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, st, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL below_base_rdata: got %h, expected 0", rd); end
    n_chk++;
    if (berr[2] !== 1'b1) begin n_fail++; $display("FAIL below_base_berr: got %b, expected 1", berr[2]); end
    idle(2);
  endtask
  task automatic test_reset_mid_stall();
    int st;
    logic [31:0] rd;
    preload(3, 32'h20, 32'hA1A2_A3A4);
    for (int ph = 0; ph < 2; ph++) begin
      addr[3] = 32'h20; wdata[3] = 32'hB1B2_B3B4; be[3] = 4'hF; wr_s[3] = 1'b1;
      tick();
      tick();
      n_chk++;
      if (wq[3] !== 1'b1) begin n_fail++; $display("FAIL midstall_wait ph%0d: got %b, expected 1", ph, wq[3]); end
      rst_n[3] = 1'b0;
      tick();
      n_chk++;
      if (wq[3] !== 1'b1) begin n_fail++; $display("FAIL midstall_reset_wait ph%0d: got %b, expected 1", ph, wq[3]); end
      rst_n[3] = 1'b1;
      if (ph == 0) begin
        wr_s[3] = 1'b0;
        tick();
      end else begin
        st = 0;
        #1;
        while (wq[3] === 1'b1 && st < 40) begin
          st++;
          tick();
        end
        n_chk++;
        if (st !== 4) begin n_fail++; $display("FAIL midstall_restart: got %0d stall cycles, expected 4", st); end
        tick();
        model_write(3, 32'h20, 32'hB1B2_B3B4, 4'hF);
        wr_s[3] = 1'b0;
      end
      xfer(3, 1'b0, 32'h20, 32'h0, 4'h0, st, rd);
      n_chk++;
      if (rd !== exp_read(3, 32'h20)) begin n_fail++; $display("FAIL midstall_rdata ph%0d: got %h, expected %h", ph, rd, exp_read(3, 32'h20)); end
      n_chk++;
      if (st !== 4) begin n_fail++; $display("FAIL midstall_read_stall ph%0d: got %0d, expected 4", ph, st); end
      idle(3);
    end
  endtask
  initial begin
    test_reset();
    test_basic_read();
    test_byte_lanes();
    test_back_to_back();
    test_collision();
    test_errors();
    test_random_wait();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/avalon_wait_ram.md
# avalon_wait_ram

Parametrised Avalon-MM slave memory model for CPU testbenches. Generalises the fixed test RAM with a configurable depth and base address, a programmable or pseudo-random `waitrequest` stall length, byte-lane writes, and a sticky bus-error flag. It also has a side preload port, so benches can load programs before or during reset. It sits on the CPU's memory-mapped bus master, one instance per bench.

## Interface
Parameters:
- ADDR_BITS, 8: word-address bits; the memory holds 2^ADDR_BITS 32-bit words.
- BASE_ADDR, 32'h00000000: byte address mapped to word 0; must be word-aligned.
- WAIT_CYCLES, 1: base stall length in cycles, 0..15.
- RANDOM_WAIT, 0: when 1, adds 0..3 pseudo-random extra stall cycles per transaction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- address  input  32  bus byte address.
- write  input  1  bus write request.
- read  input  1  bus read request.
- waitrequest  output  1  slave stall.
- writedata  input  32  bus write data.
- byteenable  input  4  write lane enables; bit n enables writedata[8n+7:8n].
- readdata  output  32  bus read data.
- preload_en  input  1  side-port word write strobe.
- preload_addr  input  32  side-port byte address, translated the same way as `address`.
- preload_data  input  32  side-port word data.
- bus_error  output  1  sticky error flag.

## Operation
- req = read | write.
- off = address − BASE_ADDR (32-bit wrap-around arithmetic).
- word = off[ADDR_BITS+1:2].
- A request is valid when all of the following hold:
  - off < 4·2^ADDR_BITS;
  - address[1:0] == 0;
  - read and write are not both high.
- Stall counter cnt, 5 bits; target tgt:
  - tgt = WAIT_CYCLES + (RANDOM_WAIT ? lfsr[1:0] : 0).
  - tgt is captured in the first cycle of a request (cnt == 0) and held in a register until the request completes.
- waitrequest = !reset_released | (req & (cnt < tgt)).
  - The first-cycle target is used combinationally while cnt == 0.
- Accept cycle: req high and waitrequest low. The transaction completes on that rising edge.
  - Valid write: mem[word] lanes with byteenable = 1 are updated; other lanes are unchanged.
  - Valid read: readdata = mem[word] (whole word, byteenable ignored).
  - Invalid request: no memory change; readdata = 0; bus_error set to 1.
  - cnt returns to 0.
- While req is high and waitrequest is high, cnt increments each cycle.
- If the master drops req before acceptance, cnt clears to 0. This is a protocol violation; no access occurs and no error is flagged.
- readdata = 32'h0 in every cycle other than a valid read accept cycle.
- Back-to-back requests are allowed. The next request starts from cnt = 0, and its tgt is re-evaluated.
- LFSR: 8-bit Fibonacci, taps for x^8+x^6+x^5+x^4+1, seed 8'h01. It advances every cycle that reset is high.
- Preload:
  - When preload_en is high, preload_data is written as a full word at the translated preload_addr.
  - This works regardless of reset.
  - Out-of-range or misaligned preload addresses are ignored, with no error.
  - If a preload and a bus write hit the same word in the same cycle, the preload wins entirely.
- Memory contents are not cleared by reset.

## Timing
- Reset (reset == 0 at a rising edge):
  - cnt = 0, LFSR = 8'h01, bus_error = 0.
  - waitrequest = 1 while reset is low; readdata = 0.
- Reset asserted mid-transaction aborts it: no memory write occurs. After release, a still-held request restarts its full stall.
- Read/write latency is tgt + 1 cycles from first req to the accept edge.
  - WAIT_CYCLES = 0 with RANDOM_WAIT = 0 accepts in the same cycle req rises, with waitrequest low throughout.
- Read data is valid combinationally in the accept cycle only.
- A write becomes visible to a read accepted in the next cycle.
- bus_error rises the cycle after the offending accept edge and stays high until reset.

## Test plan
- WAIT_CYCLES=1: preload 0x24020002 at 0x04 during reset; read 0x04 → waitrequest high for 1 cycle, readdata 0x24020002 in the accept cycle, 0 otherwise.
- Byte lanes: word 0x08 = 0x11223344; write 0xAABBCCDD with byteenable 4'b0101 → read 0x08 returns 0x11BB33DD.
- WAIT_CYCLES=0 back-to-back: write 0x10 then read 0x10 in consecutive cycles → waitrequest never high; readdata equals the written value.
- Errors:
  - read 0x402 (misaligned) → readdata 0, bus_error 1 next cycle.
  - with ADDR_BITS=8, write 0x400 → memory unchanged, bus_error stays 1.
  - reset low → bus_error 0.
- RANDOM_WAIT=1, WAIT_CYCLES=2: 50 reads → every stall length in 2..5; sequence identical across two runs from reset.
- Reset mid-stall: WAIT_CYCLES=4, write held and reset pulsed at stall cycle 2 → no write occurs; after release a full 4-cycle stall precedes acceptance; the same-cycle preload/bus-write collision leaves the preload value.
